// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core, plus ALU-control decode.
// Optional JAL support is built when MC_CTRL_JAL_EN is defined.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9
`ifdef MC_CTRL_JAL_EN
        , JAL    = 4'd10
`endif
    } state_t;

    state_t     state;
    state_t     nextState;
    state_t     decodeNext;
    logic       legalOp;
    logic [1:0] aluOp;
    logic       branch;
    logic       pcUpdate;
    logic       irWriteRaw;
    logic       memWriteRaw;
    logic       regWriteRaw;
    logic       doneRaw;
    logic       illegalRaw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    // Opcode dispatch out of DECODE; anything not listed is illegal.
    always_comb begin
        decodeNext = FETCH;
        legalOp    = 1'b1;
        case (op)
            7'b0000011, 7'b0100011: decodeNext = MEMADR;
            7'b0110011:             decodeNext = EXECUTER;
            7'b0010011:             decodeNext = EXECUTEI;
            7'b1100011:             decodeNext = BEQ;
`ifdef MC_CTRL_JAL_EN
            7'b1101111:             decodeNext = JAL;
`endif
            default:                legalOp    = 1'b0;
        endcase
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:    nextState = DECODE;
            DECODE:   nextState = decodeNext;
            MEMADR:   nextState = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState = MEMWB;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
`ifdef MC_CTRL_JAL_EN
            JAL:      nextState = ALUWB;
`endif
            default:  nextState = FETCH;
        endcase
    end

    always_comb begin
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        aluOp       = 2'b00;
        branch      = 1'b0;
        pcUpdate    = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        doneRaw     = 1'b0;
        illegalRaw  = 1'b0;
        case (state)
            FETCH: begin
                irWriteRaw = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pcUpdate   = 1'b1;
            end
            DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                illegalRaw = ~legalOp;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc   = 2'b01;
                regWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
                doneRaw = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcUpdate = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Write enables are masked during reset so an aborted instruction leaves no trace.
    assign PCWrite    = (pcUpdate | (branch & zero)) & ~reset;
    assign IRWrite    = irWriteRaw & ~reset;
    assign MemWrite   = memWriteRaw & ~reset;
    assign RegWrite   = regWriteRaw & ~reset;
    assign instr_done = doneRaw & ~reset;
    assign illegal_op = illegalRaw & ~reset;

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
`ifdef MC_CTRL_JAL_EN
            7'b1101111: ImmSrc = 2'b11;
`endif
            default:    ImmSrc = 2'b00;
        endcase
    end

    // Subtract only for R-type with funct7b5 set; I-type addi never subtracts.
    always_comb begin
        ALUControl = 3'b111;
        case (aluOp)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b111;
                endcase
            end
            default: ALUControl = 3'b111;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: fixed instruction table, reset-abort sequence,
// and random instructions against an instruction-level reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cycles;
        int regw;
        int memw;
        int pcw;
        int done;
        int illegal;
        int alu3;
        int imm;
        int lastRes;
    } summary_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        summary_t   exp;
    } vector_t;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected per-instruction behaviour, from the instruction class alone.
    function automatic summary_t modelInstr(input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input logic z);
        summary_t s;
        int func;
        s = '{cycles: 2, regw: 0, memw: 0, pcw: 1, done: 0, illegal: 1,
              alu3: 0, imm: 0, lastRes: 0};
        case (f3)
            3'd0:    func = (o[5] && f7) ? 1 : 0;
            3'd2:    func = 5;
            3'd6:    func = 3;
            3'd7:    func = 2;
            default: func = 7;
        endcase
        if (o == 7'b0000011) s = '{5, 1, 0, 1, 1, 0, 0, 0, 1};
        else if (o == 7'b0100011) s = '{4, 0, 1, 1, 1, 0, 0, 1, 0};
        else if (o == 7'b0110011 || o == 7'b0010011) s = '{4, 1, 0, 1, 1, 0, func, 0, 0};
        else if (o == 7'b1100011) s = '{3, 0, 0, 1 + int'(z), 1, 0, 1, 2, 0};
`ifdef MC_CTRL_JAL_EN
        else if (o == 7'b1101111) s = '{4, 1, 0, 2, 1, 0, 0, 3, 0};
`endif
        return s;
    endfunction

    // Runs one instruction from a FETCH cycle and summarises what the outputs did.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, output summary_t obs);
        obs = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) #1;
            else @(negedge clk);
            if (c == 3) obs.alu3 = int'(ALUControl);
            if (c > 1 && IRWrite) begin
                obs.cycles = c - 1;
                break;
            end
            if (c == 2) obs.imm = int'(ImmSrc);
            obs.pcw     += int'(PCWrite);
            obs.regw    += int'(RegWrite);
            obs.memw    += int'(MemWrite);
            obs.done    += int'(instr_done);
            obs.illegal += int'(illegal_op);
            obs.lastRes  = int'(ResultSrc);
        end
    endtask

    task automatic compareSummary(input string tag, input summary_t a, input summary_t e);
        checkOutput({tag, ".cycles"},  a.cycles,  e.cycles);
        checkOutput({tag, ".regw"},    a.regw,    e.regw);
        checkOutput({tag, ".memw"},    a.memw,    e.memw);
        checkOutput({tag, ".pcw"},     a.pcw,     e.pcw);
        checkOutput({tag, ".done"},    a.done,    e.done);
        checkOutput({tag, ".illegal"}, a.illegal, e.illegal);
        checkOutput({tag, ".alu3"},    a.alu3,    e.alu3);
        checkOutput({tag, ".imm"},     a.imm,     e.imm);
        checkOutput({tag, ".lastRes"}, a.lastRes, e.lastRes);
    endtask

    initial begin
        vector_t    vecs[12];
        summary_t   obs;
        logic [6:0] opPool[8];

        vecs[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, '{5, 1, 0, 1, 1, 0, 0, 0, 1}};
        vecs[1]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, '{4, 0, 1, 1, 1, 0, 0, 1, 0}};
        vecs[2]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, '{4, 1, 0, 1, 1, 0, 1, 0, 0}};
        vecs[3]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, '{4, 1, 0, 1, 1, 0, 0, 0, 0}};
        vecs[4]  = '{7'b0110011, 3'd2, 1'b0, 1'b0, '{4, 1, 0, 1, 1, 0, 5, 0, 0}};
        vecs[5]  = '{7'b0110011, 3'd6, 1'b0, 1'b1, '{4, 1, 0, 1, 1, 0, 3, 0, 0}};
        vecs[6]  = '{7'b0010011, 3'd7, 1'b0, 1'b0, '{4, 1, 0, 1, 1, 0, 2, 0, 0}};
        vecs[7]  = '{7'b0110011, 3'd1, 1'b0, 1'b0, '{4, 1, 0, 1, 1, 0, 7, 0, 0}};
        vecs[8]  = '{7'b1100011, 3'd0, 1'b0, 1'b1, '{3, 0, 0, 2, 1, 0, 1, 2, 0}};
        vecs[9]  = '{7'b1100011, 3'd0, 1'b0, 1'b0, '{3, 0, 0, 1, 1, 0, 1, 2, 0}};
`ifdef MC_CTRL_JAL_EN
        vecs[10] = '{7'b1101111, 3'd0, 1'b0, 1'b0, '{4, 1, 0, 2, 1, 0, 0, 3, 0}};
`else
        vecs[10] = '{7'b1101111, 3'd0, 1'b0, 1'b0, '{2, 0, 0, 1, 0, 1, 0, 0, 0}};
`endif
        vecs[11] = '{7'b0110111, 3'd0, 1'b0, 1'b0, '{2, 0, 0, 1, 0, 1, 0, 0, 0}};

        reset = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        checkOutput("rst.PCWrite",   int'(PCWrite),   0);
        checkOutput("rst.IRWrite",   int'(IRWrite),   0);
        checkOutput("rst.RegWrite",  int'(RegWrite),  0);
        checkOutput("rst.ALUSrcB",   int'(ALUSrcB),   2);
        checkOutput("rst.ResultSrc", int'(ResultSrc), 2);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, obs);
            compareSummary($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Abort a store while MemWrite is asserted.
        op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort.MemWriteBefore", int'(MemWrite), 1);
        reset = 1'b1;
        #1;
        checkOutput("abort.MemWrite", int'(MemWrite),   0);
        checkOutput("abort.done",     int'(instr_done), 0);
        checkOutput("abort.AdrSrc",   int'(AdrSrc),     0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort.IRWrite", int'(IRWrite), 1);
        checkOutput("abort.PCWrite", int'(PCWrite), 1);

        opPool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                   7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
        for (int n = 0; n < 60; n++) begin
            logic [6:0] ro;
            logic [2:0] rf3;
            logic       rf7, rz;
            ro  = opPool[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) ro = 7'($urandom_range(0, 127));
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 1'($urandom_range(0, 1));
            rz  = 1'($urandom_range(0, 1));
            applyStimulus(ro, rf3, rf7, rz, obs);
            compareSummary($sformatf("rnd%0d", n), obs, modelInstr(ro, rf3, rf7, rz));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RV32I core: an 11-state Moore FSM that sequences fetch, decode, address generation, memory access, execute and writeback over the shared ALU, memory port and register file. It drives every datapath enable and mux select, and contains the ALU-control decode that maps the internal ALUOp plus funct fields to the 3-bit ALU operation code. It sits beside the datapath, fed by the instruction register's op/funct fields and the ALU zero flag.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  instruction opcode (instr[6:0])
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register / OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
- ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 unsupported
- instr_done  out  1  high in the final state of each instruction
- illegal_op  out  1  high in DECODE when op is unsupported

## Operation
- Internal signals: 4-bit state register, 2-bit ALUOp, Branch, PCUpdate; PCWrite = PCUpdate | (Branch & zero).
- Unlisted outputs are 0 in each state. Transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
    - 0000011 or 0100011 goes to MEMADR.
    - 0110011 goes to EXECUTER.
    - 0010011 goes to EXECUTEI.
    - 1100011 goes to BEQ.
    - 1101111 goes to JAL.
    - Anything else: illegal_op=1, next is FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- ImmSrc is combinational from op and independent of state: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, otherwise 00.
- ALUControl decode:
  - ALUOp=00 gives 000; ALUOp=01 gives 001.
  - ALUOp=10, by funct3:
    - 000: 001 if {op[5],funct7b5}=11, else 000.
    - 010: 101.
    - 110: 011.
    - 111: 010.
    - Otherwise: 111.
  - ALUOp=11 gives 111.
- Unused state encodings go to FETCH on the next edge, with all enables 0 while there.

## Timing
- Moore outputs are combinational from state; PCWrite additionally depends combinationally on zero in BEQ.
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, jal 4, illegal 2.
- Reset value: state=FETCH. While reset=1, PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_op are forced to 0; selects show FETCH values (AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10).
- Reset asserted mid-instruction aborts it immediately, with no partial write. The first cycle after release is FETCH.
- op, funct3 and funct7b5 are sampled combinationally each cycle; the IR must hold them stable from DECODE to the end of the instruction.

## Configuration
- MC_CTRL_JAL_EN defined: JAL state present; op 1101111 follows DECODE→JAL→ALUWB, and ImmSrc=11 for that op.
- MC_CTRL_JAL_EN undefined: no JAL state; op 1101111 is illegal (illegal_op=1 in DECODE, next FETCH) and ImmSrc=00.

## Test plan
- Reset pulse in MEMWRITE with op=0100011 → MemWrite drops to 0 immediately; after release, FETCH with IRWrite=1 and PCWrite=1.
- lw (op=0000011) → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only; instr_done high once.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. The same with op=0010011 → 000 (addi). funct3=010 → 101.
- beq with zero=1 → PCWrite=1 in BEQ. With zero=0 → PCWrite=0; ALUControl=001 in both cases.
- jal → DECODE ImmSrc=11, JAL with PCWrite=1, ALUWB with RegWrite=1; 4 cycles total. Without MC_CTRL_JAL_EN: illegal_op=1 and back to FETCH after 2 cycles.
- Unsupported op=0110111 → illegal_op=1 in DECODE; no PCWrite, RegWrite or MemWrite after FETCH.
